// File: rtl/conware_pkg.sv
// rtl/conware_pkg.sv - shared types and constants for the conware row evaluators
package conware_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    localparam int SUM_W  = 3;
    localparam int NCNT_W = 4;

    localparam logic [8:0] DEF_BIRTH_MASK   = 9'h008;
    localparam logic [8:0] DEF_SURVIVE_MASK = 9'h00C;

endpackage

// File: rtl/conware_rule_lut.sv
// rtl/conware_rule_lut.sv - one lane's birth/survive decision from its window and neighbour sums
module conware_rule_lut
    import conware_pkg::*;
#(
    parameter logic [8:0] BIRTH_MASK   = DEF_BIRTH_MASK,
    parameter logic [8:0] SURVIVE_MASK = DEF_SURVIVE_MASK
) (
    input  logic             i_c,
    input  logic             i_l,
    input  logic             i_r,
    input  logic [SUM_W-1:0] i_up,
    input  logic [SUM_W-1:0] i_dn,
    output logic             o_next
);

    logic [NCNT_W-1:0] w_n;

    // The centre cell is deliberately left out of the neighbour count.
    assign w_n = NCNT_W'(i_up) + NCNT_W'(i_dn) + NCNT_W'(i_l) + NCNT_W'(i_r);

    assign o_next = (w_n > NCNT_W'(8)) ? 1'b0
                  : (i_c ? SURVIVE_MASK[w_n] : BIRTH_MASK[w_n]);

endmodule

// File: rtl/shredder_vec.sv
// rtl/shredder_vec.sv - multi-lane Life row evaluator; CONWARE_SHREDDER_POP_EN adds row population output
module shredder_vec
    import conware_pkg::*;
#(
    parameter int         LANES        = 4,
    parameter int         ROW_BEATS    = 8,
    parameter logic [8:0] BIRTH_MASK   = DEF_BIRTH_MASK,
    parameter logic [8:0] SURVIVE_MASK = DEF_SURVIVE_MASK
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_bits,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W*LANES-1:0]   out_sum,
    input  logic [SUM_W*LANES-1:0]   nsum_up,
    input  logic [SUM_W*LANES-1:0]   nsum_dn,
    output logic [LANES-1:0]         out_state,
    output logic                     out_last,
    output logic                     len_err
`ifdef CONWARE_SHREDDER_POP_EN
    ,
    output logic [$clog2(LANES*ROW_BEATS+1)-1:0] pop_count,
    output logic                     pop_valid
`endif
);

    localparam int CNT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_BEATS - 1);

    state_t                   r_state;
    logic [LANES-1:0]         r_cur;
    logic                     r_prev_msb;
    logic [CNT_W-1:0]         r_cnt;
    logic [LANES-1:0]         r_oc;
    logic [LANES-1:0]         r_ol;
    logic [LANES-1:0]         r_or;
    logic [SUM_W*LANES-1:0]   r_osum;
    logic                     r_olast;
    logic                     r_ovalid;
    logic                     r_len_err;

    logic                     w_slot_free;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_is_last;
    logic                     w_nxt;
    logic [LANES-1:0]         w_l;
    logic [LANES-1:0]         w_r;
    logic [SUM_W*LANES-1:0]   w_sum;

    assign w_slot_free = !r_ovalid || out_ready;

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            ST_EMPTY: in_ready = 1'b1;
            ST_HOLD:  in_ready = w_slot_free;
            default:  in_ready = 1'b0;
        endcase
    end

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_ovalid && out_ready;
    assign w_is_last  = (r_cnt == LAST_IDX);
    // Right neighbour of the top lane is the incoming beat's lane 0, or padding once the row has ended.
    assign w_nxt      = (r_state == ST_HOLD) ? in_bits[0] : 1'b0;

    always_comb begin
        w_l    = r_cur << 1;
        w_l[0] = r_prev_msb;
        w_r    = r_cur >> 1;
        w_r[LANES-1] = w_nxt;
        w_sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum[SUM_W*i +: SUM_W] = SUM_W'(w_l[i]) + SUM_W'(r_cur[i]) + SUM_W'(w_r[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_EMPTY;
            r_cur      <= '0;
            r_prev_msb <= 1'b0;
            r_cnt      <= '0;
            r_oc       <= '0;
            r_ol       <= '0;
            r_or       <= '0;
            r_osum     <= '0;
            r_olast    <= 1'b0;
            r_ovalid   <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            if (w_out_fire) begin
                r_ovalid <= 1'b0;
            end
            if (w_in_fire && (in_last != w_is_last)) begin
                r_len_err <= 1'b1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_cur      <= in_bits;
                        r_prev_msb <= 1'b0;
                        r_cnt      <= w_is_last ? '0 : r_cnt + CNT_W'(1);
                        r_state    <= w_is_last ? ST_TAIL : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_in_fire) begin
                        r_oc       <= r_cur;
                        r_ol       <= w_l;
                        r_or       <= w_r;
                        r_osum     <= w_sum;
                        r_olast    <= 1'b0;
                        r_ovalid   <= 1'b1;
                        r_prev_msb <= r_cur[LANES-1];
                        r_cur      <= in_bits;
                        r_cnt      <= w_is_last ? '0 : r_cnt + CNT_W'(1);
                        r_state    <= w_is_last ? ST_TAIL : ST_HOLD;
                    end
                end
                ST_TAIL: begin
                    if (w_slot_free) begin
                        r_oc     <= r_cur;
                        r_ol     <= w_l;
                        r_or     <= w_r;
                        r_osum   <= w_sum;
                        r_olast  <= 1'b1;
                        r_ovalid <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = r_ovalid;
    assign out_sum   = r_osum;
    assign out_last  = r_olast;
    assign len_err   = r_len_err;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        conware_rule_lut #(
            .BIRTH_MASK   (BIRTH_MASK),
            .SURVIVE_MASK (SURVIVE_MASK)
        ) u_lut (
            .i_c    (r_oc[g]),
            .i_l    (r_ol[g]),
            .i_r    (r_or[g]),
            .i_up   (nsum_up[SUM_W*g +: SUM_W]),
            .i_dn   (nsum_dn[SUM_W*g +: SUM_W]),
            .o_next (out_state[g])
        );
    end

`ifdef CONWARE_SHREDDER_POP_EN
    localparam int POP_W = $clog2(LANES*ROW_BEATS+1);

    logic [POP_W-1:0] r_pop_acc;
    logic [POP_W-1:0] r_pop_count;
    logic             r_pop_valid;
    logic [POP_W-1:0] w_pop_beat;

    always_comb begin
        w_pop_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop_beat = w_pop_beat + POP_W'(out_state[i]);
        end
    end

    // Counted at the handshake because out_state depends on the neighbour sums presented then.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pop_acc   <= '0;
            r_pop_count <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            if (w_out_fire) begin
                if (r_olast) begin
                    r_pop_count <= r_pop_acc + w_pop_beat;
                    r_pop_acc   <= '0;
                    r_pop_valid <= 1'b1;
                end else begin
                    r_pop_acc <= r_pop_acc + w_pop_beat;
                end
            end
        end
    end

    assign pop_count = r_pop_count;
    assign pop_valid = r_pop_valid;
`endif

endmodule
